// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch with timeout guard and valid/ready handoff.
// Optional INSTR_FETCH_MISALIGN_CHECK_EN faults misaligned start PCs without a bus read.
module instr_fetch_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] pc,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        busy
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   instr_pc_q, instr_pc_d;
    logic          fault_q, fault_d;
    logic [1:0]    cause_q, cause_d;
    logic          mem_rd_q, mem_rd_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic          launch;
    logic          misaligned;

`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    assign misaligned = |pc[1:0];
`else
    assign misaligned = 1'b0;
`endif

    assign launch = start &
                    ((state_q == IDLE) ||
                     ((state_q == HOLD) && out_ready));

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        fault_d    = fault_q;
        cause_d    = cause_q;

        unique case (state_q)
            IDLE: ;
            REQ: begin
                // An ack on the limit cycle takes priority over the timeout.
                if (mem_ack) begin
                    instr_d    = mem_err ? 32'h0 : mem_rdata;
                    fault_d    = mem_err;
                    cause_d    = mem_err ? 2'd1 : 2'd0;
                    instr_pc_d = pc_q;
                    state_d    = HOLD;
                end else if (cnt_q == CNT_LIMIT) begin
                    instr_d    = 32'h0;
                    fault_d    = 1'b1;
                    cause_d    = 2'd2;
                    instr_pc_d = pc_q;
                    state_d    = HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            pc_d  = pc;
            cnt_d = '0;
            if (misaligned) begin
                instr_d    = 32'h0;
                instr_pc_d = pc;
                fault_d    = 1'b1;
                cause_d    = 2'd3;
                state_d    = HOLD;
            end else begin
                state_d = REQ;
            end
        end

        mem_rd_d    = (state_d == REQ);
        out_valid_d = (state_d == HOLD);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= 32'h0;
            cnt_q       <= '0;
            instr_q     <= 32'h0;
            instr_pc_q  <= 32'h0;
            fault_q     <= 1'b0;
            cause_q     <= 2'd0;
            mem_rd_q    <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            fault_q     <= fault_d;
            cause_q     <= cause_d;
            mem_rd_q    <= mem_rd_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_rd      = mem_rd_q;
    assign mem_addr    = mem_rd_q ? {pc_q[31:2], 2'b00} : 32'h0;
    assign out_valid   = out_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign fault       = fault_q;
    assign fault_cause = cause_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (TIMEOUT_CYCLES=4).
// Define INSTR_FETCH_MISALIGN_CHECK_EN to exercise the misalignment fault path.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] pc;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fault;
    logic [1:0]  fault_cause;
    logic        busy;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pc          (pc),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .mem_err     (mem_err),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .fault       (fault),
        .fault_cause (fault_cause),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL rst_mem_rd got %b exp 0", mem_rd); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if ({instr, instr_pc} !== 64'h0) begin errors++; $display("FAIL rst_instr got %h/%h exp 0/0", instr, instr_pc); end
        checks++; if ({fault, fault_cause} !== 3'b000) begin errors++; $display("FAIL rst_fault got %b/%0d exp 0/0", fault, fault_cause); end
    endtask

    task automatic test_basic();
        pc = 32'h100;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL basic_mem_rd got %b exp 1", mem_rd); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL basic_addr got %h exp 100", mem_addr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", out_valid); end
        mem_ack = 1'b1;
        mem_rdata = 32'h13;
        tick();
        mem_ack = 1'b0;
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL basic_rd_drop got %b exp 0", mem_rd); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", out_valid); end
        checks++; if (instr !== 32'h13) begin errors++; $display("FAIL basic_instr got %h exp 13", instr); end
        checks++; if (instr_pc !== 32'h100) begin errors++; $display("FAIL basic_pc got %h exp 100", instr_pc); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL basic_fault got %b exp 0", fault); end
        handoff();
        checks++; if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL basic_idle got %b%b exp 00", out_valid, busy); end
    endtask

    task automatic test_back_to_back();
        pc = 32'h200;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL wait_rd got %b exp 1", mem_rd); end
        mem_ack = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        // start while decode stalls must not disturb the held word
        start = 1'b1;
        pc = 32'h300;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || instr !== 32'hDEADBEEF ||
                instr_pc !== 32'h200 || fault !== 1'b0 || mem_rd !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable[%0d] got v=%b i=%h pc=%h f=%b rd=%b exp 1/deadbeef/200/0/0",
                         i, out_valid, instr, instr_pc, fault, mem_rd);
            end
            tick();
        end
        pc = 32'h104;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL b2b_rd got %b exp 1", mem_rd); end
        checks++; if (mem_addr !== 32'h104) begin errors++; $display("FAIL b2b_addr got %h exp 104", mem_addr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid got %b exp 0", out_valid); end
        mem_ack = 1'b1;
        mem_rdata = 32'h00500093;
        tick();
        mem_ack = 1'b0;
        checks++; if (instr !== 32'h00500093 || instr_pc !== 32'h104) begin errors++; $display("FAIL b2b_data got %h/%h exp 00500093/104", instr, instr_pc); end
        handoff();
    endtask

    task automatic test_bus_error();
        pc = 32'h400;
        start = 1'b1;
        tick();
        start = 1'b0;
        mem_ack = 1'b1;
        mem_err = 1'b1;
        mem_rdata = 32'h12345678;
        tick();
        mem_ack = 1'b0;
        mem_err = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL berr_valid got %b exp 1", out_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL berr_instr got %h exp 0", instr); end
        checks++; if ({fault, fault_cause} !== 3'b101) begin errors++; $display("FAIL berr_cause got %b/%0d exp 1/1", fault, fault_cause); end
        checks++; if (instr_pc !== 32'h400) begin errors++; $display("FAIL berr_pc got %h exp 400", instr_pc); end
        handoff();
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        pc = 32'h500;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) break;
            if (mem_rd) n++;
            tick();
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL tmo_rd_cycles got %0d exp 4", n); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL tmo_valid got %b exp 1", out_valid); end
        checks++; if ({fault, fault_cause} !== 3'b110) begin errors++; $display("FAIL tmo_cause got %b/%0d exp 1/2", fault, fault_cause); end
        checks++; if (instr !== 32'h0 || instr_pc !== 32'h500) begin errors++; $display("FAIL tmo_data got %h/%h exp 0/500", instr, instr_pc); end
        handoff();
        pc = 32'h504;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL tmo_edge_rd got %b exp 1", mem_rd); end
        mem_ack = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 1'b0;
        checks++; if ({fault, fault_cause} !== 3'b000) begin errors++; $display("FAIL tmo_edge_cause got %b/%0d exp 0/0", fault, fault_cause); end
        checks++; if (instr !== 32'hCAFEF00D || instr_pc !== 32'h504) begin errors++; $display("FAIL tmo_edge_data got %h/%h exp cafef00d/504", instr, instr_pc); end
        handoff();
    endtask

    task automatic test_reset_mid();
        pc = 32'h600;
        start = 1'b1;
        tick();
        start = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if ({mem_rd, out_valid, busy} !== 3'b000) begin errors++; $display("FAIL rmid_state got %b%b%b exp 000", mem_rd, out_valid, busy); end
        mem_ack = 1'b1;
        mem_rdata = 32'h1;
        tick();
        mem_ack = 1'b0;
        checks++; if ({mem_rd, out_valid, busy} !== 3'b000) begin errors++; $display("FAIL rmid_late_ack got %b%b%b exp 000", mem_rd, out_valid, busy); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rmid_instr got %h exp 0", instr); end
    endtask

    task automatic test_misalign();
        pc = 32'h102;
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL mis_rd got %b exp 0", mem_rd); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mis_valid got %b exp 1", out_valid); end
        checks++; if ({fault, fault_cause} !== 3'b111) begin errors++; $display("FAIL mis_cause got %b/%0d exp 1/3", fault, fault_cause); end
        checks++; if (instr !== 32'h0 || instr_pc !== 32'h102) begin errors++; $display("FAIL mis_data got %h/%h exp 0/102", instr, instr_pc); end
`else
        checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL mis_rd got %b exp 1", mem_rd); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL mis_addr got %h exp 100", mem_addr); end
        mem_ack = 1'b1;
        mem_rdata = 32'h33;
        tick();
        mem_ack = 1'b0;
        checks++; if ({fault, fault_cause} !== 3'b000) begin errors++; $display("FAIL mis_cause got %b/%0d exp 0/0", fault, fault_cause); end
        checks++; if (instr !== 32'h33 || instr_pc !== 32'h102) begin errors++; $display("FAIL mis_data got %h/%h exp 33/102", instr, instr_pc); end
`endif
        handoff();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mis_idle got %b exp 0", busy); end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        pc = 32'h0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        mem_err = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_bus_error();
        test_timeout();
        test_reset_mid();
        test_misalign();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly downstream of the program counter register. It takes the current PC and issues a single-word read on the instruction memory bus. It waits for the acknowledge, with a timeout guard, then holds the fetched word and its PC for the decode stage on a valid/ready handshake. One fetch is outstanding at a time; bus errors, timeouts and optional misalignment are reported as tagged faults.

Parameters:
TIMEOUT_CYCLES, 255, max REQ cycles without mem_ack before timeout fault; counter width = $clog2(TIMEOUT_CYCLES+1); legal range 1..65535

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous reset, active high
start  input  1  begin fetch at pc; honoured in IDLE, or in HOLD during handoff
pc  input  32  fetch address from program counter
mem_rd  output  1  read request; held high for the whole REQ state
mem_addr  output  32  word address {pc_q[31:2],2'b00}; stable while mem_rd=1
mem_ack  input  1  read complete this cycle; sampled only in REQ
mem_rdata  input  32  read data; valid when mem_ack=1
mem_err  input  1  bus error qualifier; valid when mem_ack=1
out_valid  output  1  instr/instr_pc/fault valid for decode
out_ready  input  1  decode accepts when out_valid & out_ready
instr  output  32  fetched instruction word (0 on any fault)
instr_pc  output  32  PC the word was fetched from
fault  output  1  fetch faulted
fault_cause  output  2  0 none, 1 bus error, 2 timeout, 3 misaligned
busy  output  1  state != IDLE

Behaviour:
- States: IDLE, REQ, HOLD. Reset → IDLE; mem_rd, mem_addr, out_valid, instr, instr_pc, fault, fault_cause, busy, timeout counter all 0.
- IDLE: start=1 → pc_q<=pc, counter<=0, next state REQ. start=0 → stay in IDLE. mem_ack ignored.
- REQ: mem_rd=1, mem_addr from pc_q. start ignored.
  - mem_ack=1, mem_err=0: instr<=mem_rdata, fault<=0, cause<=0.
  - mem_ack=1, mem_err=1: instr<=0, fault<=1, cause<=1.
  - Either ack case: instr_pc<=pc_q, next state HOLD.
  - mem_ack=0 and counter==TIMEOUT_CYCLES-1: instr<=0, fault<=1, cause<=2, instr_pc<=pc_q, next state HOLD.
  - Otherwise counter increments.
  - An ack arriving in the same cycle as the timeout limit wins; no timeout fault.
- HOLD: out_valid=1; instr, instr_pc, fault and cause stay stable until handoff.
  - Handoff = out_ready=1. With start=0 → IDLE. With start=1 → latch new pc, counter<=0, go straight to REQ (back-to-back, no IDLE bubble).
  - out_ready=0: stay in HOLD; start ignored.
- Latency: start in cycle N → mem_rd=1 in N+1. mem_ack in cycle M → out_valid=1 in M+1. Minimum start-to-valid is 2 cycles. Sustained throughput is one word per 2 cycles with a zero-wait bus.
- mem_rd deasserts in the cycle after ack or timeout.
- Reset mid-operation (REQ or HOLD): next cycle is IDLE with all outputs 0. A late mem_ack arriving in IDLE is ignored.
- pc[1:0] never drives mem_addr.

Optional Feature:
INSTR_FETCH_MISALIGN_CHECK_EN
- Defined: start with pc[1:0]!=0 (IDLE or HOLD handoff) skips REQ and goes to HOLD next cycle with instr=0, instr_pc=pc, fault=1, cause=3. No mem_rd is issued.
- Not defined: pc[1:0] is ignored and the aligned word is fetched normally. Cause 3 is never produced.

Test Plan:
- Reset, then start with pc=0x00000100; mem_ack at the first REQ cycle with rdata=0x00000013 → mem_rd=1 for 1 cycle, mem_addr=0x100; out_valid=1 two cycles after start with instr=0x13, instr_pc=0x100, fault=0.
- Wait states: ack 3 cycles into REQ with rdata=0xDEADBEEF, out_ready held 0 for 4 cycles → outputs stable throughout HOLD; handoff with start=1 and pc=0x104 → REQ next cycle, mem_addr=0x104.
- Bus error: ack with mem_err=1, rdata=0x12345678 → instr=0, fault=1, cause=1, instr_pc=fetch PC.
- Timeout with TIMEOUT_CYCLES=4 and no ack → mem_rd high exactly 4 cycles, then fault=1, cause=2. Repeat with ack on the 4th REQ cycle → normal completion, fault=0.
- Reset in REQ with an ack arriving the following cycle → IDLE, mem_rd=0, out_valid stays 0.
- Macro defined, start with pc=0x102 → mem_rd never asserted; next cycle out_valid=1, fault=1, cause=3, instr_pc=0x102. Macro undefined → mem_addr=0x100, normal fetch.
